// File: rtl/vm_change_dispenser.sv
// Coin payout unit: greedily dispenses a change amount as 20/10/5 coins,
// tracking inventory and waiting for a hopper acknowledge after each coin.
module vm_change_dispenser #(
  parameter int CNT_W    = 4,
  parameter int INIT_CNT = 10,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       amount,
  input  logic             refill,
  input  logic             eject_ack,
  output logic             eject_20,
  output logic             eject_10,
  output logic             eject_5,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [5:0]       paid,
  output logic [CNT_W-1:0] cnt20,
  output logic [CNT_W-1:0] cnt10,
  output logic [CNT_W-1:0] cnt5
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(INIT_CNT);
  localparam logic [TW-1:0]    TIMER_END = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT} state_t;
  typedef enum logic [1:0] {COIN_20, COIN_10, COIN_5} coin_t;

  state_t          state;
  coin_t           coin_sel;
  logic [5:0]      remaining;
  logic [TW-1:0]   timer;
  logic [5:0]      coin_val;

  always_comb begin
    coin_val = 6'd5;
    case (coin_sel)
      COIN_20: coin_val = 6'd20;
      COIN_10: coin_val = 6'd10;
      default: coin_val = 6'd5;
    endcase
  end

  // Selection only picks a coin that fits and is in stock, so remaining
  // never underflows and counts never wrap below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      coin_sel  <= COIN_20;
      remaining <= 6'd0;
      timer     <= '0;
      paid      <= 6'd0;
      eject_20  <= 1'b0;
      eject_10  <= 1'b0;
      eject_5   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      cnt20     <= FULL_CNT;
      cnt10     <= FULL_CNT;
      cnt5      <= FULL_CNT;
    end else begin
      eject_20 <= 1'b0;
      eject_10 <= 1'b0;
      eject_5  <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            paid <= 6'd0;
            busy <= 1'b1;
            if (amount == 6'd0) begin
              state <= DONE;
            end else if ((amount % 6'd5) != 6'd0) begin
              state <= FAULT;
            end else begin
              remaining <= amount;
              state     <= SELECT;
            end
          end else if (refill) begin
            cnt20 <= FULL_CNT;
            cnt10 <= FULL_CNT;
            cnt5  <= FULL_CNT;
          end
        end
        SELECT: begin
          if (remaining >= 6'd20 && cnt20 != '0) begin
            coin_sel <= COIN_20;
            state    <= EJECT;
          end else if (remaining >= 6'd10 && cnt10 != '0) begin
            coin_sel <= COIN_10;
            state    <= EJECT;
          end else if (remaining >= 6'd5 && cnt5 != '0) begin
            coin_sel <= COIN_5;
            state    <= EJECT;
          end else if (remaining == 6'd0) begin
            state <= DONE;
          end else begin
            state <= FAULT;
          end
        end
        EJECT: begin
          eject_20 <= (coin_sel == COIN_20);
          eject_10 <= (coin_sel == COIN_10);
          eject_5  <= (coin_sel == COIN_5);
          timer    <= '0;
          state    <= WAIT_ACK;
        end
        // An ack on the final allowed cycle still counts as a paid coin.
        WAIT_ACK: begin
          if (eject_ack) begin
            remaining <= remaining - coin_val;
            paid      <= paid + coin_val;
            case (coin_sel)
              COIN_20: cnt20 <= cnt20 - CNT_W'(1);
              COIN_10: cnt10 <= cnt10 - CNT_W'(1);
              default: cnt5  <= cnt5 - CNT_W'(1);
            endcase
            state <= SELECT;
          end else if (timer == TIMER_END) begin
            state <= FAULT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAULT: begin
          fault <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Self-checking bench for vm_change_dispenser: directed scenarios plus
// randomized payouts compared against a greedy change-making model.
module tb_vm_change_dispenser;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset, start, refill, eject_ack;
  logic [5:0]       amount;
  logic             eject_20, eject_10, eject_5, busy, done, fault;
  logic [5:0]       paid;
  logic [CNT_W-1:0] cnt20, cnt10, cnt5;

  int n_checks = 0;
  int n_pass   = 0;

  // model inventory and expected outcome
  int inv20, inv10, inv5;
  int m_seq[$];
  int m_paid;
  bit m_done;

  // observed outcome of the last payout
  int r_seq[$];
  bit r_done, r_fault, r_multi;
  int r_lat, r_wait;
  logic [5:0] r_paid;

  vm_change_dispenser #(.CNT_W(CNT_W), .INIT_CNT(10), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount), .refill(refill),
    .eject_ack(eject_ack), .eject_20(eject_20), .eject_10(eject_10), .eject_5(eject_5),
    .busy(busy), .done(done), .fault(fault), .paid(paid),
    .cnt20(cnt20), .cnt10(cnt10), .cnt5(cnt5)
  );

  always #5 clk = ~clk;

  // Greedy change-making straight from the rules: biggest coin that fits and is in stock.
  task automatic model_pay(input int amt);
    int rem;
    m_seq.delete();
    m_paid = 0;
    m_done = 1'b0;
    if (amt % 5 != 0) return;
    rem = amt;
    forever begin
      if (rem >= 20 && inv20 > 0) begin inv20--; rem -= 20; m_seq.push_back(20); end
      else if (rem >= 10 && inv10 > 0) begin inv10--; rem -= 10; m_seq.push_back(10); end
      else if (rem >= 5 && inv5 > 0) begin inv5--; rem -= 5; m_seq.push_back(5); end
      else break;
    end
    m_paid = amt - rem;
    m_done = (rem == 0);
  endtask

  function automatic bit seq_match();
    if (r_seq.size() != m_seq.size()) return 1'b0;
    foreach (r_seq[i]) if (r_seq[i] != m_seq[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit cnts_match();
    return (cnt20 == CNT_W'(inv20)) && (cnt10 == CNT_W'(inv10)) && (cnt5 == CNT_W'(inv5));
  endfunction

  // Drives one payout and acks each coin after 0..max_delay cycles (or never).
  task automatic do_payout(input logic [5:0] amt, input int max_delay, input bit withhold,
                           input bit with_refill, input bit poke_start);
    int pending;
    int last_ej;
    r_seq.delete();
    r_done = 0; r_fault = 0; r_multi = 0; r_lat = -1; r_wait = -1; r_paid = 'x;
    pending = -1; last_ej = 0;
    @(negedge clk);
    amount = amt; start = 1'b1; refill = with_refill;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = poke_start && (cyc == 4);
      refill = 1'b0;
      eject_ack = 1'b0;
      if (int'(eject_20) + int'(eject_10) + int'(eject_5) > 1) r_multi = 1;
      if (eject_20) r_seq.push_back(20);
      if (eject_10) r_seq.push_back(10);
      if (eject_5)  r_seq.push_back(5);
      if (eject_20 || eject_10 || eject_5) begin
        last_ej = cyc;
        pending = withhold ? -1 : int'($urandom_range(max_delay, 0));
      end
      if (pending == 0) begin eject_ack = 1'b1; pending = -1; end
      else if (pending > 0) pending--;
      if (done || fault) begin
        r_done = done; r_fault = fault; r_lat = cyc; r_wait = cyc - last_ej; r_paid = paid;
        break;
      end
    end
    eject_ack = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_refill();
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    inv20 = 10; inv10 = 10; inv5 = 10;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; refill = 0; eject_ack = 0; amount = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if ({eject_20, eject_10, eject_5, done, fault} !== 5'b0)
      $display("FAIL reset_pulses got %b want 00000", {eject_20, eject_10, eject_5, done, fault}); else n_pass++;
    n_checks++; if (paid !== 6'd0) $display("FAIL reset_paid got %0d want 0", paid); else n_pass++;
    n_checks++; if ({cnt20, cnt10, cnt5} !== {4'd10, 4'd10, 4'd10})
      $display("FAIL reset_cnts got %0d/%0d/%0d want 10/10/10", cnt20, cnt10, cnt5); else n_pass++;
    reset = 1'b0;
    inv20 = 10; inv10 = 10; inv5 = 10;
  endtask

  task automatic test_basic_35();
    model_pay(35);
    do_payout(6'd35, 0, 0, 0, 0);
    n_checks++; if (!(r_seq.size() == 3 && r_seq[0] == 20 && r_seq[1] == 10 && r_seq[2] == 5))
      $display("FAIL basic_order got %0d coins want 20,10,5", r_seq.size()); else n_pass++;
    n_checks++; if (!(r_done && r_lat == 12)) $display("FAIL basic_latency got done=%0b at %0d want done at 12", r_done, r_lat); else n_pass++;
    n_checks++; if (r_paid !== 6'd35) $display("FAIL basic_paid got %0d want 35", r_paid); else n_pass++;
    n_checks++; if ({cnt20, cnt10, cnt5} !== {4'd9, 4'd9, 4'd9})
      $display("FAIL basic_cnts got %0d/%0d/%0d want 9/9/9", cnt20, cnt10, cnt5); else n_pass++;
  endtask

  task automatic test_illegal_17();
    model_pay(17);
    do_payout(6'd17, 0, 0, 0, 0);
    n_checks++; if (!(r_fault && r_lat == 2)) $display("FAIL illegal_fault got fault=%0b at %0d want fault at 2", r_fault, r_lat); else n_pass++;
    n_checks++; if (r_seq.size() != 0) $display("FAIL illegal_no_eject got %0d coins want 0", r_seq.size()); else n_pass++;
    n_checks++; if (r_paid !== 6'd0) $display("FAIL illegal_paid got %0d want 0", r_paid); else n_pass++;
    n_checks++; if (!cnts_match()) $display("FAIL illegal_cnts got %0d/%0d/%0d want %0d/%0d/%0d", cnt20, cnt10, cnt5, inv20, inv10, inv5); else n_pass++;
  endtask

  task automatic test_drain_20();
    do_refill();
    for (int i = 0; i < 3; i++) begin model_pay(60); do_payout(6'd60, 0, 0, 0, 0); end
    model_pay(20); do_payout(6'd20, 0, 0, 0, 0);
    n_checks++; if (cnt20 !== 4'd0) $display("FAIL drain_cnt20 got %0d want 0", cnt20); else n_pass++;
    model_pay(40); do_payout(6'd40, 1, 0, 0, 0);
    n_checks++; if (!(r_seq.size() == 4 && r_seq[0] == 10 && r_seq[3] == 10 && seq_match()))
      $display("FAIL drain_tens got %0d coins want four 10s", r_seq.size()); else n_pass++;
    n_checks++; if (!(r_done && r_paid == 6'd40)) $display("FAIL drain_done got done=%0b paid=%0d want 1/40", r_done, r_paid); else n_pass++;
    n_checks++; if (cnt10 !== 4'd6) $display("FAIL drain_cnt10 got %0d want 6", cnt10); else n_pass++;
  endtask

  task automatic test_partial_fault();
    model_pay(60); do_payout(6'd60, 0, 0, 0, 0);
    model_pay(45); do_payout(6'd45, 0, 0, 0, 0);
    n_checks++; if ({cnt20, cnt10, cnt5} !== {4'd0, 4'd0, 4'd1})
      $display("FAIL partial_setup got %0d/%0d/%0d want 0/0/1", cnt20, cnt10, cnt5); else n_pass++;
    model_pay(15); do_payout(6'd15, 0, 0, 0, 0);
    n_checks++; if (!(r_seq.size() == 1 && r_seq[0] == 5)) $display("FAIL partial_eject got %0d coins want one 5", r_seq.size()); else n_pass++;
    n_checks++; if (!(r_fault && !r_done)) $display("FAIL partial_fault got fault=%0b done=%0b want 1/0", r_fault, r_done); else n_pass++;
    n_checks++; if (r_paid !== 6'd5) $display("FAIL partial_paid got %0d want 5", r_paid); else n_pass++;
    n_checks++; if (cnt5 !== 4'd0) $display("FAIL partial_cnt5 got %0d want 0", cnt5); else n_pass++;
  endtask

  task automatic test_timeout_refill();
    do_refill();
    model_pay(25); do_payout(6'd25, 0, 0, 0, 0);
    do_payout(6'd20, 0, 1, 0, 0);
    n_checks++; if (!(r_seq.size() == 1 && r_seq[0] == 20)) $display("FAIL timeout_eject got %0d coins want one 20", r_seq.size()); else n_pass++;
    n_checks++; if (!(r_fault && r_wait >= TIMEOUT && r_wait <= TIMEOUT + 1))
      $display("FAIL timeout_fault got fault=%0b after %0d want fault after %0d", r_fault, r_wait, TIMEOUT); else n_pass++;
    n_checks++; if (r_paid !== 6'd0) $display("FAIL timeout_paid got %0d want 0", r_paid); else n_pass++;
    n_checks++; if (cnt20 !== 4'd9) $display("FAIL timeout_cnt20 got %0d want 9", cnt20); else n_pass++;
    do_refill();
    @(negedge clk);
    n_checks++; if ({cnt20, cnt10, cnt5} !== {4'd10, 4'd10, 4'd10})
      $display("FAIL refill_cnts got %0d/%0d/%0d want 10/10/10", cnt20, cnt10, cnt5); else n_pass++;
  endtask

  task automatic test_reset_midpayout();
    bit seen;
    model_pay(5); do_payout(6'd5, 0, 0, 0, 0);
    n_checks++; if (cnt5 !== 4'd9) $display("FAIL midreset_setup got %0d want 9", cnt5); else n_pass++;
    @(negedge clk); amount = 6'd30; start = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (eject_20 || eject_10 || eject_5) begin seen = 1; break; end
    end
    n_checks++; if (!seen) $display("FAIL midreset_eject got none want one"); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if ({cnt20, cnt10, cnt5} !== {4'd10, 4'd10, 4'd10})
      $display("FAIL midreset_cnts got %0d/%0d/%0d want 10/10/10", cnt20, cnt10, cnt5); else n_pass++;
    @(negedge clk); reset = 1'b0;
    inv20 = 10; inv10 = 10; inv5 = 10;
  endtask

  task automatic test_busy_ignore();
    bit extra;
    model_pay(60);
    do_payout(6'd60, 2, 0, 0, 1);
    n_checks++; if (!(r_done && seq_match())) $display("FAIL busy_payout got done=%0b coins=%0d want 1/%0d", r_done, r_seq.size(), m_seq.size()); else n_pass++;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || eject_20 || eject_10 || eject_5) extra = 1;
    end
    n_checks++; if (extra) $display("FAIL busy_no_second got activity want idle"); else n_pass++;
    n_checks++; if (!cnts_match()) $display("FAIL busy_cnts got %0d/%0d/%0d want %0d/%0d/%0d", cnt20, cnt10, cnt5, inv20, inv10, inv5); else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] amt;
    bit rf;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(5, 0) == 0) amt = 6'($urandom_range(63, 0));
      else amt = 6'(5 * $urandom_range(12, 0));
      rf = ($urandom_range(3, 0) == 0);
      if (inv20 + inv10 + inv5 < 5) do_refill();
      model_pay(int'(amt));
      do_payout(amt, 3, 0, rf, 0);
      n_checks++; if (r_done !== m_done || r_fault !== !m_done)
        $display("FAIL rand_outcome amt=%0d got done=%0b fault=%0b want done=%0b", amt, r_done, r_fault, m_done); else n_pass++;
      n_checks++; if (!seq_match()) $display("FAIL rand_coins amt=%0d got %0d coins want %0d", amt, r_seq.size(), m_seq.size()); else n_pass++;
      n_checks++; if (r_paid !== 6'(m_paid)) $display("FAIL rand_paid amt=%0d got %0d want %0d", amt, r_paid, m_paid); else n_pass++;
      n_checks++; if (!cnts_match()) $display("FAIL rand_cnts amt=%0d got %0d/%0d/%0d want %0d/%0d/%0d", amt, cnt20, cnt10, cnt5, inv20, inv10, inv5); else n_pass++;
      n_checks++; if (r_multi) $display("FAIL rand_one_hot amt=%0d got multiple ejects want at most one", amt); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_35();
    test_illegal_17();
    test_drain_20();
    test_partial_fault();
    test_timeout_refill();
    test_reset_midpayout();
    test_busy_ignore();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
